// File: rtl/gfsk_tx_pkg.sv
// gfsk_tx_pkg: shared states, constants and counter-width helper for the GFSK tx controller
package gfsk_tx_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DRAIN} state_t;
  localparam int BITS_PER_BYTE = 8;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gfsk_tx_byte_prefetch.sv
// gfsk_tx_byte_prefetch: one-entry byte buffer with valid/ready fill, same-cycle bypass and pop/empty drain
module gfsk_tx_byte_prefetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       en,
  input  logic [7:0] byte_in,
  input  logic       byte_in_valid,
  input  logic       pop,
  output logic       ready,
  output logic [7:0] data,
  output logic       avail,
  output logic       empty
);
  logic       full;
  logic [7:0] buf_q;
  always_comb begin
    ready = en && !full;
    empty = !full;
    avail = full || (ready && byte_in_valid);
    data  = full ? buf_q : byte_in;
  end
  always_ff @(posedge clk) begin
    if (rst || flush || pop) begin
      full <= 1'b0;
      if (rst) buf_q <= '0;
    end else if (ready && byte_in_valid) begin
      full  <= 1'b1;
      buf_q <= byte_in;
    end
  end
endmodule

// File: rtl/gfsk_tx_controller.sv
// gfsk_tx_controller: packet sequencer serializing bytes LSB-first at symbol pace, then draining the modulator
module gfsk_tx_controller
  import gfsk_tx_pkg::*;
#(
  parameter int SAMPLE_PER_SYMBOL = 8,
  parameter int LEN_BIT_WIDTH     = 8,
  parameter int DRAIN_TIMEOUT     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_start,
  input  logic [LEN_BIT_WIDTH-1:0] tx_len_byte,
  input  logic [7:0]               byte_in,
  input  logic                     byte_in_valid,
  output logic                     byte_in_ready,
  output logic                     phy_bit,
  output logic                     bit_valid,
  output logic                     bit_valid_last,
  input  logic                     sin_cos_out_valid_last,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic                     tx_err
);
  localparam int SW = cnt_w(SAMPLE_PER_SYMBOL);
  localparam int DW = cnt_w(DRAIN_TIMEOUT);
  localparam logic [SW-1:0] SYM_LAST   = SW'(SAMPLE_PER_SYMBOL - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);
  state_t                   state;
  logic [BITS_PER_BYTE-1:0] sreg;
  logic [3:0]               bit_cnt;
  logic [SW-1:0]            sym_cnt;
  logic [DW-1:0]            drain_cnt;
  logic [LEN_BIT_WIDTH-1:0] bytes_left;
  logic                     err_flag;
  logic                     slot, need, hs, pf_en, pf_flush, pf_ready, pf_pop, pf_avail, pf_empty;
  logic [7:0]               pf_data;
  assign slot          = state == SHIFT && sym_cnt == SYM_LAST;
  assign need          = slot && bit_cnt == 4'(BITS_PER_BYTE);
  assign pf_en         = state == SHIFT && bytes_left != '0;
  assign pf_flush      = state != SHIFT;
  assign pf_pop        = need && pf_avail;
  assign byte_in_ready = state == LOAD || pf_ready;
  assign hs            = byte_in_valid && byte_in_ready;
  assign tx_busy       = state != IDLE;
  gfsk_tx_byte_prefetch u_prefetch (
    .clk           (clk),
    .rst           (rst),
    .flush         (pf_flush),
    .en            (pf_en),
    .byte_in       (byte_in),
    .byte_in_valid (byte_in_valid),
    .pop           (pf_pop),
    .ready         (pf_ready),
    .data          (pf_data),
    .avail         (pf_avail),
    .empty         (pf_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sreg           <= '0;
      bit_cnt        <= '0;
      sym_cnt        <= '0;
      drain_cnt      <= '0;
      bytes_left     <= '0;
      err_flag       <= 1'b0;
      phy_bit        <= 1'b0;
      bit_valid      <= 1'b0;
      bit_valid_last <= 1'b0;
      tx_done        <= 1'b0;
      tx_err         <= 1'b0;
    end else begin
      bit_valid      <= 1'b0;
      bit_valid_last <= 1'b0;
      tx_done        <= 1'b0;
      tx_err         <= 1'b0;
      if (hs && bytes_left != '0) bytes_left <= bytes_left - 1'b1;
      case (state)
        IDLE: begin
          if (tx_start && tx_len_byte == '0) tx_err <= 1'b1;
          else if (tx_start) begin
            bytes_left <= tx_len_byte;
            err_flag   <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (byte_in_valid) begin
            phy_bit   <= byte_in[0];
            bit_valid <= 1'b1;
            sreg      <= byte_in >> 1;
            bit_cnt   <= 4'd1;
            sym_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          sym_cnt   <= slot ? '0 : sym_cnt + 1'b1;
          drain_cnt <= '0;
          if (slot) begin
            bit_valid <= 1'b1;
            if (!need) begin
              phy_bit <= sreg[0];
              sreg    <= sreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 4'(BITS_PER_BYTE - 1) && bytes_left == '0 && pf_empty) begin
                bit_valid_last <= 1'b1;
                state          <= DRAIN;
              end
            end else if (pf_avail) begin
              phy_bit <= pf_data[0];
              sreg    <= pf_data >> 1;
              bit_cnt <= 4'd1;
            end else begin
              phy_bit        <= 1'b0;
              bit_valid_last <= 1'b1;
              tx_err         <= 1'b1;
              err_flag       <= 1'b1;
              state          <= DRAIN;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (sin_cos_out_valid_last) begin
            tx_done <= !err_flag;
            state   <= IDLE;
          end else if (drain_cnt == DRAIN_LAST) begin
            tx_err <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gfsk_tx_controller.sv
// tb_gfsk_tx_controller: directed and randomized packet checks against a bit-list reference model
module tb_gfsk_tx_controller;
  localparam int SPS = 8;
  logic       clk = 0, rst = 1, tx_start = 0, tx_start_b = 0, byte_in_valid = 0, scl = 0;
  logic [7:0] tx_len_byte = 0, byte_in = 0;
  logic       byte_in_ready, phy_bit, bit_valid, bit_valid_last, tx_busy, tx_done, tx_err;
  logic       byte_in_ready_b, phy_bit_b, bit_valid_b, bit_valid_last_b, tx_busy_b, tx_done_b, tx_err_b;
  int         n_assert = 0, n_fail = 0, cyc = 0, ptr = 0, feed_lim = 0;
  logic [7:0] pkt[$];
  int         bt[$], done_q[$], err_q[$], hs_q[$];
  bit         bb[$], bl[$];
  int         rdy_last = -1, bl_b = -1, err_b_c = -1, b_bits = 0, b_done = 0;
  bit         busy_seen = 0, busy_at_err_b = 1;
  logic [7:0] b_byte = 0;

  gfsk_tx_controller #(.SAMPLE_PER_SYMBOL(SPS), .LEN_BIT_WIDTH(8), .DRAIN_TIMEOUT(1024)) u_dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_len_byte(tx_len_byte),
    .byte_in(byte_in), .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready),
    .phy_bit(phy_bit), .bit_valid(bit_valid), .bit_valid_last(bit_valid_last),
    .sin_cos_out_valid_last(scl), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );
  gfsk_tx_controller #(.SAMPLE_PER_SYMBOL(SPS), .LEN_BIT_WIDTH(8), .DRAIN_TIMEOUT(16)) u_dut_b (
    .clk(clk), .rst(rst), .tx_start(tx_start_b), .tx_len_byte(tx_len_byte),
    .byte_in(byte_in), .byte_in_valid(byte_in_valid), .byte_in_ready(byte_in_ready_b),
    .phy_bit(phy_bit_b), .bit_valid(bit_valid_b), .bit_valid_last(bit_valid_last_b),
    .sin_cos_out_valid_last(1'b0), .tx_busy(tx_busy_b), .tx_done(tx_done_b), .tx_err(tx_err_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit hs;
    @(negedge clk);
    if (bit_valid) begin bt.push_back(cyc); bb.push_back(phy_bit); bl.push_back(bit_valid_last); end
    if (tx_done) done_q.push_back(cyc);
    if (tx_err) err_q.push_back(cyc);
    if (tx_busy) busy_seen = 1;
    if (byte_in_ready) rdy_last = cyc;
    if (byte_in_valid && byte_in_ready) hs_q.push_back(cyc);
    if (bit_valid_b) begin b_bits++; b_byte = {phy_bit_b, b_byte[7:1]}; end
    if (bit_valid_last_b) bl_b = cyc;
    if (tx_err_b) begin err_b_c = cyc; busy_at_err_b = tx_busy_b; end
    if (tx_done_b) b_done++;
    hs = byte_in_valid && (byte_in_ready || byte_in_ready_b);
    @(posedge clk);
    #1;
    cyc++;
    tx_start = 0; tx_start_b = 0; scl = 0;
    if (hs) ptr++;
    byte_in_valid = ptr < feed_lim;
    byte_in = ptr < pkt.size() ? pkt[ptr] : 8'h00;
  endtask

  task automatic clear();
    bt.delete(); bb.delete(); bl.delete(); done_q.delete(); err_q.delete(); hs_q.delete();
    rdy_last = -1; busy_seen = 0;
  endtask

  task automatic feed(input int lim);
    ptr = 0; feed_lim = lim; byte_in_valid = lim > 0; byte_in = pkt[0];
  endtask

  task automatic run_pkt(input string tag, input int lim, input int vl_delay, input int inject_at);
    int len, nexp, t_vl, c0, n;
    bit under, injected, eb;
    logic [7:0] b;
    len = pkt.size(); under = lim < len; nexp = under ? 8 * lim + 1 : 8 * len;
    clear(); feed(lim);
    tx_len_byte = 8'(len); tx_start = 1; c0 = cyc; t_vl = -1; injected = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cyc == t_vl) scl = 1;
      if (!injected && inject_at >= 0 && bt.size() == inject_at) begin
        tx_start = 1; tx_len_byte = 8'd5; injected = 1;
      end
      step();
      if (t_vl < 0 && bl.size() > 0 && bl[$]) t_vl = bt[$] + vl_delay;
      if (t_vl >= 0 && cyc > t_vl + 1) break;
    end
    chk({tag, " bit count"}, bt.size(), nexp);
    n = bt.size() < nexp ? bt.size() : nexp;
    for (int i = 0; i < n; i++) begin
      b = pkt[i / 8];
      eb = (under && i == nexp - 1) ? 1'b0 : b[i % 8];
      chk($sformatf("%s bit%0d value", tag, i), bb[i], eb);
      chk($sformatf("%s bit%0d last", tag, i), bl[i], i == nexp - 1);
      if (i > 0) chk($sformatf("%s bit%0d spacing", tag, i), bt[i] - bt[i - 1], SPS);
    end
    chk({tag, " handshakes"}, hs_q.size(), lim);
    chk({tag, " first handshake"}, hs_q.size() > 0 ? hs_q[0] : -1, c0 + 1);
    chk({tag, " first bit"}, bt.size() > 0 ? bt[0] : -1, c0 + 2);
    chk({tag, " done count"}, done_q.size(), under ? 0 : 1);
    if (!under) chk({tag, " done time"}, done_q.size() > 0 ? done_q[0] : -1, t_vl + 1);
    chk({tag, " err count"}, err_q.size(), under);
    if (under) begin
      chk({tag, " err time"}, err_q.size() > 0 ? err_q[0] : -1, bt.size() > 0 ? bt[$] : -2);
      chk({tag, " no ready after underrun"}, rdy_last < (bt.size() > 0 ? bt[$] : 0), 1);
    end
    chk({tag, " busy after"}, tx_busy, 0);
  endtask

  initial begin
    int c0, ones;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {byte_in_ready, phy_bit, bit_valid, bit_valid_last, tx_busy, tx_done, tx_err}, 0);
    chk("reset outputs b", {byte_in_ready_b, phy_bit_b, bit_valid_b, bit_valid_last_b, tx_busy_b, tx_done_b, tx_err_b}, 0);
    @(posedge clk);
    #1;
    rst = 0;
    repeat (2) step();

    pkt = '{8'hA5};
    run_pkt("len1 A5", 1, 20, -1);

    pkt = '{8'h01, 8'h80, 8'hFF};
    run_pkt("len3 ignore start", 3, 7, 10);

    pkt = '{8'h3C, 8'h99};
    run_pkt("underrun", 1, 5, -1);

    clear(); tx_len_byte = 0; tx_start = 1; c0 = cyc;
    repeat (3) step();
    chk("zero len err count", err_q.size(), 1);
    chk("zero len err time", err_q.size() > 0 ? err_q[0] : -1, c0 + 1);
    chk("zero len busy", busy_seen, 0);

    repeat (3) begin
      int len;
      len = $urandom_range(1, 4);
      pkt.delete();
      repeat (len) pkt.push_back(8'($urandom_range(0, 255)));
      run_pkt($sformatf("random len%0d", len), len, $urandom_range(1, 30), -1);
    end

    pkt.delete();
    repeat (6) pkt.push_back(8'($urandom_range(0, 255)));
    clear(); feed(6); tx_len_byte = 8'd6; tx_start = 1;
    for (int i = 0; i < 1000 && bt.size() < 27; i++) step();
    rst = 1;
    step();
    rst = 0; feed_lim = 0; byte_in_valid = 0;
    @(negedge clk);
    chk("mid rst outputs", {byte_in_ready, phy_bit, bit_valid, bit_valid_last, tx_busy, tx_done, tx_err}, 0);
    ones = 0;
    foreach (bl[i]) ones += bl[i];
    chk("mid rst no last", ones, 0);
    chk("mid rst no done/err", done_q.size() + err_q.size(), 0);
    chk("mid rst reached byte4", bt.size() >= 27, 1);
    @(posedge clk);
    #1;
    cyc++;
    pkt = '{8'h6D};
    run_pkt("after rst", 1, 3, -1);

    pkt = '{8'($urandom_range(0, 255))};
    feed(1); b_bits = 0; bl_b = -1; err_b_c = -1; b_done = 0;
    tx_len_byte = 8'd1; tx_start_b = 1;
    repeat (110) step();
    chk("timeout bits", b_bits, 8);
    chk("timeout byte", b_byte, pkt[0]);
    chk("timeout err time", err_b_c, bl_b < 0 ? -3 : bl_b + 16);
    chk("timeout busy at err", busy_at_err_b, 0);
    chk("timeout no done", b_done, 0);
    chk("timeout idle", tx_busy_b, 0);
    tx_len_byte = 8'd1; tx_start_b = 1;
    step();
    chk("timeout restart busy", tx_busy_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
